keccak_round_scheduler: RTL

- Sequences the Keccak-f permutation: for each of Rounds rounds, runs NumSteps slice-serial step units in fixed order. Step 0 is the column-parity/theta unit; the remaining units are rho, pi, chi and iota.
- Owns the shared 64x25 slice-state RAM port: streams slices out to the selected step and writes its results back in place.
- Sits between the top-level permutation wrapper and the step units. Each step unit exposes start/ready/putInput/outReady handshakes.

---
 rtl/keccak_sched_pkg.sv | 22 ++
 rtl/sched_slice_counter.sv | 33 +++
 rtl/keccak_round_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/keccak_sched_pkg.sv
// Shared definitions for the Keccak-f round scheduler: FSM encoding,
// step-unit indices and default state geometry.
package keccak_sched_pkg;

  localparam int CountDefault = 64;
  localparam int WidthDefault = 25;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    NEXT  = 3'd4
  } schedState_e;

  localparam logic [2:0] STEP_THETA = 3'd0;
  localparam logic [2:0] STEP_RHO   = 3'd1;
  localparam logic [2:0] STEP_PI    = 3'd2;
  localparam logic [2:0] STEP_CHI   = 3'd3;
  localparam logic [2:0] STEP_IOTA  = 3'd4;

endpackage

// File: rtl/sched_slice_counter.sv
// Slice counter shared by the FEED and DRAIN phases; wraps to 0 on the
// Count-th enabled cycle and flags that cycle on tc.
module sched_slice_counter #(
  parameter int Count = 64,
  parameter int AdrW  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  output logic [AdrW-1:0] cnt,
  output logic            tc
);

  // One spare bit so a full Count never reads back as slice 0.
  localparam logic [AdrW:0] LastVal = (AdrW+1)'(Count - 1);

  logic [AdrW:0] cntReg;

  assign tc  = en && (cntReg == LastVal);
  assign cnt = cntReg[AdrW-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      cntReg <= '0;
    end else if (clr || tc) begin
      cntReg <= '0;
    end else if (en) begin
      cntReg <= cntReg + 1'b1;
    end
  end

endmodule

// File: rtl/keccak_round_scheduler.sv
// Keccak-f round scheduler: runs the step units in order for every round and
// owns the slice-RAM port. Optional protocol checker: SCHED_PROTOCOL_CHECK_EN.
module keccak_round_scheduler
  import keccak_sched_pkg::*;
#(
  parameter int Count    = CountDefault,
  parameter int Width    = WidthDefault,
  parameter int NumSteps = 5,
  parameter int Rounds   = 24,
  parameter int AdrW     = 6,
  parameter int SelW     = 3,
  parameter int RoundW   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      ready,
  output logic                      done,
  output logic [RoundW-1:0]         roundIdx,
  output logic [SelW-1:0]           stepSel,
  output logic [NumSteps-1:0]       stepStart,
  input  logic [NumSteps-1:0]       stepPutInput,
  input  logic [NumSteps-1:0]       stepOutReady,
  input  logic [NumSteps*Width-1:0] stepOut,
  output logic [AdrW-1:0]           memAdr,
  output logic                      memRead,
  output logic                      memWrite,
  output logic [Width-1:0]          memWData,
  output logic                      err,
  output logic [2:0]                stateDbg
);

  schedState_e       state;
  logic [SelW-1:0]   stepIdx;
  logic [SelW-1:0]   nextIdx;
  logic              putSel;
  logic              outSel;
  logic [Width-1:0]  selOut;
  logic [AdrW-1:0]   sliceCnt;
  logic              cntEn;
  logic              cntClr;
  logic              cntTc;

  // Handshake: a slice moves in whichever cycle the selected unit's putInput
  // (FEED) or outReady (DRAIN) is high; the scheduler is always ready in those
  // phases, so the unit's bit alone is the transfer, with no backpressure.
  always_comb begin
    putSel = 1'b0;
    outSel = 1'b0;
    selOut = '0;
    for (int k = 0; k < NumSteps; k++) begin
      if (stepIdx == SelW'(k)) begin
        putSel = stepPutInput[k];
        outSel = stepOutReady[k];
        selOut = stepOut[k*Width +: Width];
      end
    end
  end

  assign nextIdx = stepIdx + SelW'(1);
  assign cntEn   = ((state == FEED) && putSel) || ((state == DRAIN) && outSel);
  assign cntClr  = (state == START);

  sched_slice_counter #(
    .Count (Count),
    .AdrW  (AdrW)
  ) u_sliceCounter (
    .clk (clk),
    .rst (rst),
    .clr (cntClr),
    .en  (cntEn),
    .cnt (sliceCnt),
    .tc  (cntTc)
  );

  // Strobes are gated by rst so an abort never commits a RAM write.
  assign memAdr   = sliceCnt;
  assign memRead  = rst && (state == FEED) && putSel;
  assign memWrite = rst && (state == DRAIN) && outSel;
  assign memWData = selOut;
  assign ready    = (state == IDLE);
  assign stepSel  = stepIdx;
  assign stateDbg = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      stepIdx   <= '0;
      roundIdx  <= '0;
      stepStart <= '0;
      done      <= 1'b0;
    end else begin
      stepStart <= '0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= START;
            stepIdx   <= '0;
            roundIdx  <= '0;
            stepStart <= NumSteps'(1);
          end
        end
        START: state <= FEED;
        FEED:  if (cntTc) state <= DRAIN;
        DRAIN: if (cntTc) state <= NEXT;
        NEXT: begin
          if (stepIdx < SelW'(NumSteps - 1)) begin
            stepIdx   <= nextIdx;
            stepStart <= NumSteps'(1) << nextIdx;
            state     <= START;
          end else begin
            stepIdx <= '0;
            if (roundIdx == RoundW'(Rounds - 1)) begin
              roundIdx <= '0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              roundIdx  <= roundIdx + RoundW'(1);
              stepStart <= NumSteps'(1);
              state     <= START;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCHED_PROTOCOL_CHECK_EN
  logic [NumSteps-1:0] otherMask;
  logic                protoViol;

  always_comb begin
    otherMask = ~(NumSteps'(1) << stepIdx);
    protoViol = ((state == FEED) && outSel) || ((state == DRAIN) && putSel) ||
                (|((stepPutInput | stepOutReady) & otherMask));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (protoViol) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
